// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// registered overflow/underflow pulses and optional first-word-fall-through read.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            data_out,
  output logic                         rd_valid,
  output logic                         f_empty,
  output logic                         f_full,
  output logic                         f_almost_empty,
  output logic                         f_almost_full,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              aempty_q, aempty_d;
  logic              afull_q, afull_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Acceptance uses the pre-edge flags, so at full a read wins and at empty a write wins.
  assign wr_acc = wr_en & ~full_q & ~rst;
  assign rd_acc = rd_en & ~empty_q & ~rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en & full_q;
    underflow_d = rd_en & empty_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    aempty_d = (count_d <= AE_C);
    afull_d  = (count_d >= AF_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      aempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      aempty_q    <= aempty_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
      assign rd_valid = ~empty_q;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q, dout_d;
      logic              rd_valid_q, rd_valid_d;

      always_comb begin
        dout_d     = dout_q;
        rd_valid_d = rd_acc;
        if (rd_acc) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          dout_q     <= dout_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign data_out = dout_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign count          = count_q;
  assign f_empty        = empty_q;
  assign f_full         = full_q;
  assign f_almost_empty = aempty_q;
  assign f_almost_full  = afull_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances share one stimulus stream
// and are compared each cycle against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_rv, f_rv, s_emp, f_emp, s_full, f_full, s_ae, f_ae, s_af, f_af;
  logic [CW-1:0] s_cnt, f_cnt;
  logic          s_ovf, f_ovf, s_udf, f_udf;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(s_dout), .rd_valid(s_rv), .f_empty(s_emp), .f_full(s_full),
    .f_almost_empty(s_ae), .f_almost_full(s_af), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf));

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_dout), .rd_valid(f_rv), .f_empty(f_emp), .f_full(f_full),
    .f_almost_empty(f_ae), .f_almost_full(f_af), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout_s = '0;
  logic          exp_rv_s = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, then check both DUTs.
  task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    int sz;
    logic was_full, was_empty;
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_dout_s = '0; exp_rv_s = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      exp_ovf   = w && was_full;
      exp_udf   = rd && was_empty;
      exp_rv_s  = rd && !was_empty;
      if (rd && !was_empty) exp_dout_s = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    sz = q.size();
    chk("s_count", 32'(s_cnt), 32'(sz));
    chk("f_count", 32'(f_cnt), 32'(sz));
    chk("s_empty", 32'(s_emp), 32'(sz == 0));
    chk("f_empty", 32'(f_emp), 32'(sz == 0));
    chk("s_full", 32'(s_full), 32'(sz == DEPTH));
    chk("f_full", 32'(f_full), 32'(sz == DEPTH));
    chk("s_aempty", 32'(s_ae), 32'(sz <= AE));
    chk("f_aempty", 32'(f_ae), 32'(sz <= AE));
    chk("s_afull", 32'(s_af), 32'(sz >= AF));
    chk("f_afull", 32'(f_af), 32'(sz >= AF));
    chk("s_overflow", 32'(s_ovf), 32'(exp_ovf));
    chk("f_overflow", 32'(f_ovf), 32'(exp_ovf));
    chk("s_underflow", 32'(s_udf), 32'(exp_udf));
    chk("f_underflow", 32'(f_udf), 32'(exp_udf));
    chk("s_data_out", 32'(s_dout), 32'(exp_dout_s));
    chk("s_rd_valid", 32'(s_rv), 32'(exp_rv_s));
    chk("f_data_out", 32'(f_dout), (sz == 0) ? 32'h0 : 32'(q[0]));
    chk("f_rd_valid", 32'(f_rv), 32'(sz != 0));
  endtask

  initial begin
    int pw, pr;

    // reset held two cycles, with requests asserted to show they are ignored
    cycle(1'b1, 1'b1, 1'b1, 8'hEE);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // fill 0..7, then one rejected write
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
    cycle(1'b0, 1'b1, 1'b0, 8'hAA);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // drain 8 words
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // underflow while empty, data_out must hold
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // simultaneous request at full
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
    cycle(1'b0, 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // simultaneous request at empty
    cycle(1'b0, 1'b1, 1'b1, 8'h33);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // streaming 1..20 through the pointer wrap
    cycle(1'b0, 1'b1, 1'b0, 8'd1);
    for (int v = 2; v <= 20; v++) cycle(1'b0, 1'b1, 1'b1, DW'(v));
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // reset at count 5, then 8'h77 must come back first
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'hC0 + i));
    cycle(1'b1, 1'b1, 1'b1, 8'h99);
    cycle(1'b0, 1'b1, 1'b0, 8'h77);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // randomized traffic with changing write/read bias and rare resets
    for (int ph = 0; ph < 6; ph++) begin
      case (ph)
        0: begin pw = 80; pr = 30; end
        1: begin pw = 30; pr = 80; end
        2: begin pw = 50; pr = 50; end
        3: begin pw = 95; pr = 90; end
        4: begin pw = 20; pr = 20; end
        default: begin pw = 70; pr = 60; end
      endcase
      for (int n = 0; n < 100; n++) begin
        cycle($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < pw,
              $urandom_range(0, 99) < pr,
              DW'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
